i2c_target_regs: RTL

- I2C target (slave) responder: the far end of the SoC's i2c0 controller.
- Bridges I2C bus transactions to a simple 8-bit register port.
- Used in bench and loopback builds as a peripheral model, and as the on-chip endpoint for board-management access.
- Standard/fast mode, 7-bit addressing, auto-incrementing register pointer, no clock stretching.

---
 rtl/i2c_target_regs.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// I2C target that bridges 7-bit-addressed bus transactions to an 8-bit register port.
// The register pointer auto-increments on each byte; the target never stretches SCL.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic [7:0]             byte_in;
    logic                   rw;
    logic                   load_pending;
    logic                   inc_pending;

    // Synchronizers idle high so reset never looks like a START or STOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in   = {shift[6:0], sda_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shift        <= 8'h00;
            rw           <= 1'b0;
            sda_oe       <= 1'b0;
            reg_addr     <= 8'h00;
            reg_wdata    <= 8'h00;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            busy         <= 1'b0;
            load_pending <= 1'b0;
            inc_pending  <= 1'b0;
        end else begin
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            load_pending <= 1'b0;
            inc_pending  <= 1'b0;
            if (load_pending)
                shift <= reg_rdata;
            if (inc_pending)
                reg_addr <= reg_addr + 8'd1;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == TARGET_ADDR) begin
                                state <= ADDR_ACK;
                                rw    <= byte_in[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    PTR: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            reg_addr <= byte_in;
                            state    <= PTR_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= WDATA_ACK;
                    end
                    // bit_cnt 0: waiting for the fall that opens the ACK clock; 1: inside it.
                    ADDR_ACK: begin
                        if (scl_fall && bit_cnt == 3'd0) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= 3'd1;
                        end else if (scl_rise && bit_cnt == 3'd1 && rw) begin
                            reg_re       <= 1'b1;
                            load_pending <= 1'b1;
                        end else if (scl_fall && bit_cnt == 3'd1) begin
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                sda_oe <= ~shift[7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall && bit_cnt == 3'd0) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= 3'd1;
                            if (state == WDATA_ACK) begin
                                reg_we      <= 1'b1;
                                reg_wdata   <= shift;
                                inc_pending <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 3'd1) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= WDATA;
                        end
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= RDATA_ACK;
                        end else begin
                            shift   <= {shift[6:0], 1'b0};
                            sda_oe  <= ~shift[6];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise && bit_cnt == 3'd0) begin
                            if (!sda_s) begin
                                reg_addr     <= reg_addr + 8'd1;
                                reg_re       <= 1'b1;
                                load_pending <= 1'b1;
                                bit_cnt      <= 3'd1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && bit_cnt == 3'd1) begin
                            sda_oe  <= ~shift[7];
                            bit_cnt <= 3'd0;
                            state   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
